// File: rtl/elevator_car_scheduler_if.sv
// Request and status bundle between one elevator car scheduler and its controller.
interface elevator_car_scheduler_if #(
  parameter int FLOORS  = 10,
  parameter int FLOOR_W = 4
);
  // req_valid is a strobe sampled on every rising edge with no back-pressure; each
  // sampled request is answered exactly one cycle later by either req_ack or req_err.
  logic               req_valid;
  logic [FLOOR_W-1:0] req_floor;
  logic               req_ack;
  logic               req_err;
  logic [FLOOR_W-1:0] cur_floor;
  logic [1:0]         elv_dir;
  logic               door_open;
  logic [FLOORS-1:0]  pending;
  logic               busy;
  logic [1:0]         state_dbg;

  modport master (
    output req_valid, req_floor,
    input  req_ack, req_err, cur_floor, elv_dir, door_open, pending, busy, state_dbg
  );

  modport slave (
    input  req_valid, req_floor,
    output req_ack, req_err, cur_floor, elv_dir, door_open, pending, busy, state_dbg
  );
endinterface

// File: rtl/elevator_car_scheduler.sv
// Per-car SCAN scheduler: keeps a pending-floor mask and sequences moves and door dwells.
module elevator_car_scheduler #(
  parameter int FLOORS     = 10,
  parameter int FLOOR_W    = 4,
  parameter int TICK_DIV   = 6000,
  parameter int MOVE_TICKS = 50,
  parameter int DOOR_TICKS = 30
) (
  input  logic                   clk,
  input  logic                   resetn,
  elevator_car_scheduler_if.slave bus
);
  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_T = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam logic [PW-1:0]      PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0]      MOVE_LAST  = TW'(MOVE_TICKS - 1);
  localparam logic [TW-1:0]      DOOR_LAST  = TW'(DOOR_TICKS - 1);
  localparam logic [FLOOR_W:0]   FLOORS_LIM = (FLOOR_W + 1)'(FLOORS);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DOOR      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d, next_floor;
  logic               up_q, up_d;
  logic [FLOORS-1:0]  pend_q, pend_d, set_mask, clr_mask;
  logic [PW-1:0]      presc_q;
  logic [TW-1:0]      tick_q;
  logic               ack_q, err_q, door_q, busy_q;
  logic [1:0]         dir_q, dir_d;
  logic               req_ok, req_bad, req_here, timer_done, restart;
  logic               any_up, any_dn;

  // True when any pending floor lies strictly above (up=1) or below (up=0) floor f.
  function automatic logic any_dir(input logic [FLOORS-1:0] p,
                                   input logic [FLOOR_W-1:0] f,
                                   input logic up);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (p[i] && (up ? (i > int'(f)) : (i < int'(f)))) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    req_ok     = bus.req_valid && ({1'b0, bus.req_floor} < FLOORS_LIM);
    req_bad    = bus.req_valid && !req_ok;
    req_here   = req_ok && (bus.req_floor == floor_q) &&
                 (state_q == S_IDLE || state_q == S_DOOR);
    state_d    = state_q;
    floor_d    = floor_q;
    up_d       = up_q;
    set_mask   = '0;
    clr_mask   = '0;
    restart    = 1'b0;
    dir_d      = 2'd3;
    any_up     = any_dir(pend_q, floor_q, 1'b1);
    any_dn     = any_dir(pend_q, floor_q, 1'b0);
    next_floor = (state_q == S_MOVE_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    timer_done = (presc_q == PRESC_LAST) &&
                 (tick_q == ((state_q == S_DOOR) ? DOOR_LAST : MOVE_LAST));

    if (req_ok && !req_here) set_mask[bus.req_floor] = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (req_here) begin
          state_d = S_DOOR;
          restart = 1'b1;
        end else if (any_up && any_dn) begin
          state_d = up_q ? S_MOVE_UP : S_MOVE_DOWN;
        end else if (any_up) begin
          state_d = S_MOVE_UP;
        end else if (any_dn) begin
          state_d = S_MOVE_DOWN;
        end
      end
      S_MOVE_UP, S_MOVE_DOWN: begin
        if (timer_done) begin
          floor_d = next_floor;
          up_d    = (state_q == S_MOVE_UP);
          restart = 1'b1;
          if (pend_q[next_floor]) begin
            clr_mask[next_floor] = 1'b1;
            state_d              = S_DOOR;
          end else if (!any_dir(pend_q, next_floor, up_d)) begin
            state_d = S_IDLE;
          end
        end
      end
      S_DOOR: begin
        // A call for this floor while the door is open extends the dwell.
        if (req_here) begin
          restart = 1'b1;
        end else if (timer_done) begin
          if (up_q ? any_up : any_dn)      state_d = up_q ? S_MOVE_UP : S_MOVE_DOWN;
          else if (up_q ? any_dn : any_up) state_d = up_q ? S_MOVE_DOWN : S_MOVE_UP;
          else                             state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A clear on arrival beats a same-edge request for that floor.
    pend_d = (pend_q | set_mask) & ~clr_mask;
    if (state_d != state_q) restart = 1'b1;

    case (state_d)
      S_MOVE_UP:   dir_d = 2'd1;
      S_MOVE_DOWN: dir_d = 2'd0;
      S_DOOR:      dir_d = 2'd2;
      default:     dir_d = 2'd3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      floor_q <= '0;
      up_q    <= 1'b1;
      pend_q  <= '0;
      presc_q <= '0;
      tick_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dir_q   <= 2'd3;
      door_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      up_q    <= up_d;
      pend_q  <= pend_d;
      ack_q   <= req_ok;
      err_q   <= req_bad;
      dir_q   <= dir_d;
      door_q  <= (state_d == S_DOOR);
      busy_q  <= (state_d != S_IDLE);
      if (restart || state_d == S_IDLE) begin
        presc_q <= '0;
        tick_q  <= '0;
      end else if (presc_q == PRESC_LAST) begin
        presc_q <= '0;
        tick_q  <= tick_q + TW'(1);
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  assign bus.req_ack   = ack_q;
  assign bus.req_err   = err_q;
  assign bus.cur_floor = floor_q;
  assign bus.elv_dir   = dir_q;
  assign bus.door_open = door_q;
  assign bus.pending   = pend_q;
  assign bus.busy      = busy_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_elevator_car_scheduler.sv
// Bench for elevator_car_scheduler: directed scenarios plus random requests against a countdown model.
module tb_elevator_car_scheduler;
  localparam int FLOORS     = 10;
  localparam int FW         = 4;
  localparam int TICK_DIV   = 4;
  localparam int MOVE_TICKS = 3;
  localparam int DOOR_TICKS = 2;
  localparam int MOVE_CYC   = TICK_DIV * MOVE_TICKS;
  localparam int DOOR_CYC   = TICK_DIV * DOOR_TICKS;

  localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3;

  logic clk = 1'b0;
  logic resetn;

  elevator_car_scheduler_if #(.FLOORS(FLOORS), .FLOOR_W(FW)) bus ();

  elevator_car_scheduler #(
    .FLOORS(FLOORS), .FLOOR_W(FW), .TICK_DIV(TICK_DIV),
    .MOVE_TICKS(MOVE_TICKS), .DOOR_TICKS(DOOR_TICKS)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase plus cycles-left countdown, pending kept as a bit array.
  int m_state;
  int m_floor;
  bit m_up;
  bit m_pend[FLOORS];
  int m_left;
  bit m_ack, m_err;

  function automatic bit m_any(input int from, input bit up);
    for (int i = 0; i < FLOORS; i++)
      if (m_pend[i] && (up ? (i > from) : (i < from))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    m_state = M_IDLE;
    m_floor = 0;
    m_up    = 1'b1;
    m_left  = 0;
    m_ack   = 1'b0;
    m_err   = 1'b0;
    for (int i = 0; i < FLOORS; i++) m_pend[i] = 1'b0;
  endtask

  task automatic m_start(input bit up);
    m_state = up ? M_UP : M_DOWN;
    m_left  = MOVE_CYC;
  endtask

  task automatic m_step(input bit rstn, input bit v, input int f);
    bit ok, here, up_now;
    int clr;
    if (!rstn) begin
      m_reset();
      return;
    end
    ok    = v && (f < FLOORS);
    here  = ok && (f == m_floor) && (m_state == M_IDLE || m_state == M_DOOR);
    clr   = -1;
    m_ack = ok;
    m_err = v && !ok;
    case (m_state)
      M_IDLE: begin
        if (here) begin
          m_state = M_DOOR;
          m_left  = DOOR_CYC;
        end else if (m_any(m_floor, 1'b1) && m_any(m_floor, 1'b0)) m_start(m_up);
        else if (m_any(m_floor, 1'b1)) m_start(1'b1);
        else if (m_any(m_floor, 1'b0)) m_start(1'b0);
      end
      M_UP, M_DOWN: begin
        m_left--;
        if (m_left == 0) begin
          up_now  = (m_state == M_UP);
          m_floor = up_now ? m_floor + 1 : m_floor - 1;
          m_up    = up_now;
          if (m_pend[m_floor]) begin
            clr     = m_floor;
            m_state = M_DOOR;
            m_left  = DOOR_CYC;
          end else if (m_any(m_floor, up_now)) m_left = MOVE_CYC;
          else m_state = M_IDLE;
        end
      end
      default: begin
        if (here) m_left = DOOR_CYC;
        else begin
          m_left--;
          if (m_left == 0) begin
            if (m_any(m_floor, m_up)) m_start(m_up);
            else if (m_any(m_floor, !m_up)) m_start(!m_up);
            else m_state = M_IDLE;
          end
        end
      end
    endcase
    if (ok && !here) m_pend[f] = 1'b1;
    if (clr >= 0) m_pend[clr] = 1'b0;
  endtask

  // scoreboard: all registered outputs against the model after every edge
  task automatic compare_all();
    logic [31:0] pend_exp;
    int dir_exp;
    pend_exp = '0;
    for (int i = 0; i < FLOORS; i++) pend_exp[i] = m_pend[i];
    case (m_state)
      M_IDLE:  dir_exp = 3;
      M_UP:    dir_exp = 1;
      M_DOWN:  dir_exp = 0;
      default: dir_exp = 2;
    endcase
    check("req_ack",   32'(bus.req_ack),   32'(m_ack));
    check("req_err",   32'(bus.req_err),   32'(m_err));
    check("cur_floor", 32'(bus.cur_floor), 32'(m_floor));
    check("elv_dir",   32'(bus.elv_dir),   32'(dir_exp));
    check("door_open", 32'(bus.door_open), 32'(m_state == M_DOOR));
    check("pending",   32'(bus.pending),   pend_exp);
    check("busy",      32'(bus.busy),      32'(m_state != M_IDLE));
  endtask

  // driver tasks
  task automatic cycle(input bit rstn, input bit v, input int f);
    resetn        = rstn;
    bus.req_valid = v;
    bus.req_floor = FW'(f);
    @(posedge clk);
    m_step(rstn, v, f);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 0);
  endtask

  task automatic wait_floor(input int f);
    for (int k = 0; k < 400 && m_floor != f; k++) cycle(1'b1, 1'b0, 0);
    check("reach_floor", 32'(bus.cur_floor), 32'(f));
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 600 && m_state != M_IDLE; k++) cycle(1'b1, 1'b0, 0);
    check("reach_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bit rr, vv;
    int ff;
    resetn        = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_floor = '0;
    m_reset();

    // reset for two cycles
    cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);

    // single trip 0 -> 3, dwell, back to idle
    cycle(1'b1, 1'b1, 3);
    run(60);

    // up to 5, collect 2 and 1 on the way back; repeat request still acks
    cycle(1'b1, 1'b1, 5);
    cycle(1'b1, 1'b1, 5);
    wait_floor(3);
    cycle(1'b1, 1'b1, 2);
    cycle(1'b1, 1'b1, 1);
    wait_idle();

    // out-of-range requests while idle and while moving
    cycle(1'b1, 1'b1, 12);
    run(3);
    cycle(1'b1, 1'b1, 7);
    run(5);
    cycle(1'b1, 1'b1, 15);
    run(3);
    wait_idle();

    // dwell extension at the current floor
    cycle(1'b1, 1'b1, 7);
    run(3);
    cycle(1'b1, 1'b1, 7);
    run(14);

    // reset in the middle of a move
    cycle(1'b0, 1'b0, 0);
    cycle(1'b1, 1'b1, 6);
    wait_floor(2);
    run(5);
    cycle(1'b0, 1'b0, 0);
    run(30);

    // random requests, occasional invalid floors and rare resets
    for (int k = 0; k < 2500; k++) begin
      rr = ($urandom_range(0, 799) != 0);
      vv = ($urandom_range(0, 5) == 0);
      ff = $urandom_range(0, 11);
      cycle(rr, vv, ff);
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
